// File: rtl/sobel_edge_pipe.sv
// sobel_edge_pipe: 3x3 Sobel edge filter on a raster pixel stream; define SOBEL_THRESH_EN to binarise the gradient outputs against iTHRESH
module sobel_edge_pipe #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 1280,
  parameter int IMG_H  = 960,
  parameter int CNT_W  = 11
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [1:0]        iMODE,
  input  logic [DATA_W-1:0] iTHRESH,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic              oEOF
);
  localparam int GW = DATA_W + 4;
  localparam logic [DATA_W-1:0] MAXV = '1;
  logic armed, acc, lastX, eofIn;
  logic [CNT_W-1:0] xCnt, yCnt, curX, curY;
  logic [1:0] mode, modeIn, m0, m1;
  logic [DATA_W-1:0] lineBuf1 [IMG_W];
  logic [DATA_W-1:0] lineBuf2 [IMG_W];
  logic [DATA_W-1:0] win [3][3];
  logic v0, border0, eof0, v1, border1, eof1;
  logic [GW-1:0] gxC, gyC, gxR, gyR, ax, ay, mag;
  logic [DATA_W-1:0] centre1, sat, res;
  // acceptance and coordinates of the pixel on the input this cycle; SOF forces (0,0)
  always_comb begin
    acc = iDVAL & (iSOF | armed);
    curX = iSOF ? '0 : xCnt;
    curY = iSOF ? '0 : yCnt;
    lastX = curX == CNT_W'(IMG_W - 1);
    eofIn = lastX && curY == CNT_W'(IMG_H - 1);
    modeIn = iSOF ? iMODE : mode;
  end
  // raster counters, frame arming and per-frame mode latch
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      armed <= 1'b0;
      xCnt <= '0;
      yCnt <= '0;
      mode <= '0;
    end else if (acc) begin
      armed <= !eofIn;
      xCnt <= lastX ? '0 : curX + 1'b1;
      yCnt <= lastX ? curY + 1'b1 : curY;
      mode <= modeIn;
    end
  end
  // line buffers: read-before-write yields rows y-1 and y-2 at column x
  always_ff @(posedge iCLK) begin
    if (acc) begin
      lineBuf1[curX] <= iDATA;
      lineBuf2[curX] <= lineBuf1[curX];
    end
  end
  // stage 0: shift the 3x3 window and capture per-pixel flags
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      v0 <= 1'b0;
      border0 <= 1'b0;
      eof0 <= 1'b0;
      m0 <= '0;
    end else begin
      v0 <= acc;
      if (acc) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lineBuf2[curX];
        win[1][2] <= lineBuf1[curX];
        win[2][2] <= iDATA;
        border0 <= curX < CNT_W'(2) || curY < CNT_W'(2);
        eof0 <= eofIn;
        m0 <= modeIn;
      end
    end
  end
  // gradients as right-minus-left and bottom-minus-top weighted column/row sums
  always_comb begin
    gxC = (GW'(win[0][2]) + (GW'(win[1][2]) << 1) + GW'(win[2][2]))
        - (GW'(win[0][0]) + (GW'(win[1][0]) << 1) + GW'(win[2][0]));
    gyC = (GW'(win[2][0]) + (GW'(win[2][1]) << 1) + GW'(win[2][2]))
        - (GW'(win[0][0]) + (GW'(win[0][1]) << 1) + GW'(win[0][2]));
  end
  // stage 1: register gradients, centre pixel and flags
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      v1 <= 1'b0;
      gxR <= '0;
      gyR <= '0;
      centre1 <= '0;
      border1 <= 1'b0;
      eof1 <= 1'b0;
      m1 <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        gxR <= gxC;
        gyR <= gyC;
        centre1 <= win[1][1];
        border1 <= border0;
        eof1 <= eof0;
        m1 <= m0;
      end
    end
  end
  // magnitude, saturation and mode selection
  always_comb begin
    ax = gxR[GW-1] ? -gxR : gxR;
    ay = gyR[GW-1] ? -gyR : gyR;
    mag = m1 == 2'd2 ? ax + ay : m1[0] ? ay : ax;
    sat = mag > GW'(MAXV) ? MAXV : mag[DATA_W-1:0];
`ifdef SOBEL_THRESH_EN
    res = border1 ? '0 : m1 == 2'd3 ? centre1 : sat >= iTHRESH ? MAXV : '0;
`else
    res = border1 ? '0 : m1 == 2'd3 ? centre1 : sat;
`endif
  end
`ifndef SOBEL_THRESH_EN
  logic unusedThresh;
  assign unusedThresh = ^iTHRESH;
`endif
  // stage 2: output register; data holds between valid pixels
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDATA <= '0;
      oDVAL <= 1'b0;
      oEOF <= 1'b0;
    end else begin
      oDVAL <= v1;
      oEOF <= v1 & eof1;
      if (v1) oDATA <= res;
    end
  end
endmodule

// File: tb/tb_sobel_edge_pipe.sv
// tb_sobel_edge_pipe: randomized stream bench for sobel_edge_pipe against a kernel-table reference model
module tb_sobel_edge_pipe;
  localparam int W = 8, H = 6, DW = 12;
  logic iCLK, iRST, iDVAL, iSOF, oDVAL, oEOF;
  logic [DW-1:0] iDATA, iTHRESH, oDATA;
  logic [1:0] iMODE;
  typedef struct { int d; bit e; int due; } exp_t;
  exp_t q[$];
  exp_t me;
  int img[H][W];
  int kx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int ky[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
  int cyc, errors, checks, thresh, lastData;
  bit monEn;

  sobel_edge_pipe #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .CNT_W(3)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
    .iMODE(iMODE), .iTHRESH(iTHRESH), .oDATA(oDATA), .oDVAL(oDVAL), .oEOF(oEOF)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int absv(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic int expPix(input int x, input int y, input int m);
    int gx, gy, mag, cx, cy;
    gx = 0;
    gy = 0;
    if (x < 2 || y < 2) return 0;
    cx = x - 1;
    cy = y - 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        gx += kx[r][c] * img[cy - 1 + r][cx - 1 + c];
        gy += ky[r][c] * img[cy - 1 + r][cx - 1 + c];
      end
    if (m == 3) return img[cy][cx];
    mag = m == 0 ? absv(gx) : m == 1 ? absv(gy) : absv(gx) + absv(gy);
    if (mag > 4095) mag = 4095;
`ifdef SOBEL_THRESH_EN
    mag = mag >= thresh ? 4095 : 0;
`endif
    return mag;
  endfunction

  task automatic build(input int pat);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = pat == 0 ? 100 : pat == 1 ? (x >= 4 ? 100 : 0) :
                    pat == 2 ? (y >= 3 ? 100 : 0) : pat == 3 ? (x >= 4 ? 4095 : 0) :
                    int'($urandom_range(4095, 0));
  endtask

  task automatic sendFrame(input int pat, input int m, input int gapMax, input int stopAt, input bit toggle);
    exp_t e;
    build(pat);
    for (int i = 0; i < stopAt; i++) begin
      repeat ($urandom_range(gapMax, 0)) begin
        @(posedge iCLK); #1;
        iDVAL = 0;
        iSOF = 0;
        iDATA = DW'($urandom);
      end
      @(posedge iCLK); #1;
      iDATA = DW'(img[i / W][i % W]);
      iDVAL = 1;
      iSOF = i == 0;
      iMODE = (toggle && i >= 20) ? ~2'(m) : 2'(m);
      e.d = expPix(i % W, i / W, m);
      e.e = i == W * H - 1;
      e.due = cyc + 3;
      q.push_back(e);
    end
    @(posedge iCLK); #1;
    iDVAL = 0;
    iSOF = 0;
  endtask

  task automatic sendLoose(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK); #1;
      iDATA = DW'($urandom);
      iDVAL = 1;
      iSOF = 0;
    end
    @(posedge iCLK); #1;
    iDVAL = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(posedge iCLK);
    chk("drain", q.size(), 0);
    repeat (4) @(posedge iCLK);
    #1;
  endtask

  task automatic setThresh(input int t);
    thresh = t;
    iTHRESH = DW'(t);
  endtask

  // scoreboard: every oDVAL pops one expectation; idle cycles check hold and EOF quiet
  always @(negedge iCLK) begin
    if (monEn) begin
      if (!iRST) lastData = 0;
      if (oDVAL) begin
        if (q.size() == 0) chk("spurious_dval", oDVAL, 0);
        else begin
          me = q.pop_front();
          chk("data", int'(oDATA), me.d);
          chk("eof", int'(oEOF), int'(me.e));
          chk("latency", cyc, me.due);
        end
        lastData = oDATA;
      end else begin
        chk("eof_idle", int'(oEOF), 0);
        chk("hold", int'(oDATA), lastData);
        if (q.size() > 0 && q[0].due < cyc) begin
          chk("missing_dval", int'(oDVAL), 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    iCLK = 0; iRST = 0; iDATA = 0; iDVAL = 0; iSOF = 0; iMODE = 0;
    setThresh(0);
    repeat (2) @(posedge iCLK);
    #1;
    monEn = 1;
    chk("rst_data", int'(oDATA), 0);
    chk("rst_dval", int'(oDVAL), 0);
    chk("rst_eof", int'(oEOF), 0);
    sendLoose(3);
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1;
    sendLoose(4);
    drain();
    sendFrame(0, 2, 0, 48, 0); drain();
    sendLoose(3); drain();
    sendFrame(1, 0, 0, 48, 0); drain();
    sendFrame(1, 0, 3, 48, 0); drain();
    sendFrame(2, 1, 0, 48, 0); drain();
    sendFrame(2, 0, 1, 48, 0); drain();
    sendFrame(3, 2, 0, 48, 0); drain();
    sendFrame(3, 3, 0, 48, 0); drain();
    sendFrame(1, 0, 0, 20, 0);
    iRST = 0;
    q.delete();
    repeat (3) @(posedge iCLK);
    #1;
    iRST = 1;
    sendLoose(5); drain();
    sendFrame(4, 2, 0, 48, 0); drain();
    sendFrame(4, 0, 0, 48, 1); drain();
    sendFrame(4, 1, 0, 48, 0); drain();
    sendFrame(4, 1, 0, 13, 0);
    sendFrame(4, 2, 1, 48, 0); drain();
    setThresh(400); sendFrame(1, 0, 0, 48, 0); drain();
    setThresh(401); sendFrame(1, 0, 0, 48, 0); drain();
    for (int k = 0; k < 4; k++) begin
      setThresh(int'($urandom_range(4095, 0)));
      sendFrame(4, int'($urandom_range(3, 0)), 2, 48, 0);
      drain();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobel_edge_pipe.md
Name: sobel_edge_pipe

Overview:
- Parametrised 3x3 Sobel edge filter on a raster-order greyscale pixel stream.
- Successor to the fixed 12-bit, 1280x960, single-kernel edge filter in the camera path. Sits between greyscale conversion and the RGB output mux.
- Generates its own pixel coordinates and owns its two line buffers.
- Adds:
  - a Gx / Gy / |Gx|+|Gy| / bypass mode select;
  - saturating arithmetic;
  - deterministic border zeroing;
  - a fixed pipeline latency;
  - an end-of-frame marker.

Parameters:
- DATA_W, 12: pixel width, unsigned.
- IMG_W, 1280: pixels per line.
- IMG_H, 960: lines per frame.
- CNT_W, 11: coordinate counter width; must satisfy 2^CNT_W >= max(IMG_W, IMG_H).

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-low.
- iDATA  in  DATA_W  greyscale pixel.
- iDVAL  in  1  pixel valid; one pixel accepted per cycle while high; gaps allowed.
- iSOF  in  1  start of frame; qualified by iDVAL; marks pixel (0,0).
- iMODE  in  2  00 Gx, 01 Gy, 10 |Gx|+|Gy|, 11 bypass (centre pixel).
- iTHRESH  in  DATA_W  binarisation threshold (see Optional Feature).
- oDATA  out  DATA_W  filtered pixel.
- oDVAL  out  1  output valid.
- oEOF  out  1  high with the oDVAL of the last pixel of a frame.

Behaviour:
- Reset: oDATA=0, oDVAL=0, oEOF=0; counters, window and pipeline registers = 0; armed=0.
- armed: set by iDVAL&iSOF. While armed=0, iDVAL pixels are ignored (no oDVAL).
- Counters x, y:
  - iDVAL&iSOF loads x=0, y=0 for that pixel.
  - Each later accepted pixel advances x.
  - x==IMG_W-1 wraps x to 0 and increments y.
  - On acceptance of pixel (IMG_W-1, IMG_H-1) the block clears armed and flags EOF. Further pixels are ignored until the next iSOF.
- iSOF mid-frame: restarts counters immediately. No flush; in-flight pipeline outputs still emerge.
- Line buffers: two IMG_W-deep DATA_W memories.
  - Written only on accepted pixels, at address x.
  - Read-before-write gives rows y-1 and y-2.
- Window: 3x3 register array. Shifts one column per accepted pixel: new column = {row y-2, row y-1, iDATA}. Window centre = input pixel (x-1, y-1).
- Kernels:
  - Gx = [-1 0 1; -2 0 2; -1 0 1]
  - Gy = [-1 -2 -1; 0 0 0; 1 2 1]
  - Row order top..bottom, column order left..right.
- Arithmetic:
  - Gx, Gy computed signed, DATA_W+4 bits; no overflow possible.
  - Modes 00/01: |G|.
  - Mode 10: |Gx|+|Gy|.
  - Result saturates to 2^DATA_W-1.
  - Mode 11: centre pixel unmodified.
- Border: if accepted pixel has x<2 or y<2, output 0 (all modes, including bypass). Centres at column IMG_W-1 and row IMG_H-1 are never produced.
- Pipeline, fixed latency 3 cycles:
  - Cycle 0: accept pixel, update window.
  - Cycle 1: register Gx, Gy, border flag, EOF flag.
  - Cycle 2: register abs/sum/saturate/mode mux.
  - Cycle 3: oDATA/oDVAL/oEOF valid.
- Exactly one oDVAL per accepted armed pixel, including zeroed borders. oDVAL is independent of iDVAL gaps; no back-pressure.
- iMODE is sampled on each iDVAL&iSOF and held for the frame. A mid-frame change has no effect.
- oDATA holds its last value while oDVAL=0. oEOF is a single-cycle pulse.
- Reset mid-operation clears everything; output restarts only after the next iSOF.

Optional Feature:
- Macro: SOBEL_THRESH_EN.
- Defined: in modes 00/01/10, the final stage outputs 2^DATA_W-1 if the saturated result >= iTHRESH, else 0. Bypass mode and border zeros are unaffected. Latency is unchanged.
- Not defined: iTHRESH is ignored and oDATA carries the saturated magnitude.

Test Plan (IMG_W=8, IMG_H=6, DATA_W=12 unless stated):
- Flat frame of 48 pixels = 100, mode 10 -> 48 oDVAL, all oDATA=0, oEOF only on the 48th, each oDVAL 3 cycles after its iDVAL.
- Vertical step (columns 0-3 = 0, columns 4-7 = 100), mode 00 -> centre columns 3 and 4 = 400 for rows y>=2 input; all other outputs = 0. Repeat with random 1-3 cycle iDVAL gaps: identical output sequence.
- Horizontal step (rows 0-2 = 0, rows 3-5 = 100), mode 01 -> centre rows 2 and 3 = 400 for x>=2; else 0. Mode 00 on the same frame -> all 0.
- Step 0 to 4095, mode 10 -> raw 16380 saturates to oDATA=4095. Mode 11 on the same frame -> centre pixels unchanged, borders 0.
- Drop iRST at pixel 20, release it, send 5 pixels without iSOF, then a full frame -> no oDVAL for those 5 pixels, then 48 correct outputs. iMODE toggled mid-frame -> no effect until the next iSOF.
- SOBEL_THRESH_EN defined, vertical-step frame, iTHRESH=400 -> step columns = 4095, others 0. iTHRESH=401 -> all 0.
